objects_mux_layered: RTL and testbench

OBJECTS_MUX_LAYERED -- requirements
Module: objects_mux_layered

---
 rtl/objects_mux_pkg.sv | 16 +
 rtl/objects_mux_arbiter.sv | 39 +++
 rtl/objects_mux_layered.sv | 167 ++++++++++++++++
 tb/tb_objects_mux_layered.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/objects_mux_pkg.sv
// -----------------------------------------------------------------------------
// objects_mux_pkg
// Shared defaults for the layered object multiplexer.
//   DEFAULT_RGB_WIDTH       : default pixel colour width
//   DEFAULT_TRANSPARENT_RGB : default colour key meaning "object not drawn"
//   rgb_t                   : pixel colour type at the default width
// -----------------------------------------------------------------------------
package objects_mux_pkg;

  localparam int DEFAULT_RGB_WIDTH = 8;

  localparam logic [DEFAULT_RGB_WIDTH-1:0] DEFAULT_TRANSPARENT_RGB = 8'hFF;

  typedef logic [DEFAULT_RGB_WIDTH-1:0] rgb_t;

endpackage

// File: rtl/objects_mux_arbiter.sv
// -----------------------------------------------------------------------------
// objects_mux_arbiter
// Combinational winner selection: among the objects whose eff bit is set, the
// one with the numerically lowest priority wins; equal priorities go to the
// lower object index.
// Ports:
//   eff    in  NUMBER_OF_OBJECTS          effective draw requests
//   prio   in  NUMBER_OF_OBJECTS x IDX_W  priority table, object i at [i*IDX_W +: IDX_W]
//   winner out IDX_W                      winning object index (0 when none)
//   any    out 1                          at least one eff bit is set
// -----------------------------------------------------------------------------
module objects_mux_arbiter #(
  parameter int NUMBER_OF_OBJECTS = 8,
  parameter int IDX_W             = $clog2(NUMBER_OF_OBJECTS)
) (
  input  logic [NUMBER_OF_OBJECTS-1:0]       eff,
  input  logic [NUMBER_OF_OBJECTS*IDX_W-1:0] prio,
  output logic [IDX_W-1:0]                   winner,
  output logic                               any
);

  logic [IDX_W-1:0] best_prio;

  // Scan upward by index; only a strictly lower priority displaces the current
  // candidate, which gives ties to the lower index.
  always_comb begin
    winner    = '0;
    any       = 1'b0;
    best_prio = '0;
    for (int i = 0; i < NUMBER_OF_OBJECTS; i++) begin
      if (eff[i] && (!any || (prio[i*IDX_W +: IDX_W] < best_prio))) begin
        any       = 1'b1;
        best_prio = prio[i*IDX_W +: IDX_W];
        winner    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/objects_mux_layered.sv
// -----------------------------------------------------------------------------
// objects_mux_layered
// Two-stage pixel compositor: picks the highest-priority drawn object per pixel
// (lowest priority value wins, ties to lower index) or the background colour.
// Optional feature macro: OBJECTS_MUX_COLLISION_EN enables sticky per-frame
// collision flags; when undefined collision_flags is tied to 0.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   pixel_valid_in         pixel inputs valid this cycle
//   frame_start            first pixel of a frame (qualified by pixel_valid_in)
//   draw_requests          per-object draw request
//   obj_RGB                per-object colour, object i at [i*RGB_WIDTH +: RGB_WIDTH]
//   background_RGB         colour when no object is drawn
//   layer_enable           per-object visibility mask
//   prio_wr_en/index/value priority-table write port
//   RGBOut                 composited pixel (2 cycles after input)
//   pixel_valid_out        pixel_valid_in delayed by 2 cycles
//   top_index              drawn object index, 0 when any_object is 0
//   any_object             an object (not background) was drawn
//   collision_flags        sticky per-frame overlap flags
// -----------------------------------------------------------------------------
module objects_mux_layered
  import objects_mux_pkg::*;
#(
  parameter int                   NUMBER_OF_OBJECTS = 8,
  parameter int                   RGB_WIDTH         = DEFAULT_RGB_WIDTH,
  parameter logic [RGB_WIDTH-1:0] TRANSPARENT_RGB   = DEFAULT_TRANSPARENT_RGB,
  localparam int                  IDX_W             = $clog2(NUMBER_OF_OBJECTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pixel_valid_in,
  input  logic                                 frame_start,
  input  logic [NUMBER_OF_OBJECTS-1:0]         draw_requests,
  input  logic [NUMBER_OF_OBJECTS*RGB_WIDTH-1:0] obj_RGB,
  input  logic [RGB_WIDTH-1:0]                 background_RGB,
  input  logic [NUMBER_OF_OBJECTS-1:0]         layer_enable,
  input  logic                                 prio_wr_en,
  input  logic [IDX_W-1:0]                     prio_wr_index,
  input  logic [IDX_W-1:0]                     prio_wr_value,
  output logic [RGB_WIDTH-1:0]                 RGBOut,
  output logic                                 pixel_valid_out,
  output logic [IDX_W-1:0]                     top_index,
  output logic                                 any_object,
  output logic [NUMBER_OF_OBJECTS-1:0]         collision_flags
);

  localparam int N = NUMBER_OF_OBJECTS;

  logic [N-1:0]           eff;
  logic [N*IDX_W-1:0]     prio_reg;
  logic [IDX_W-1:0]       win_next;
  logic                   any_next;

  // Stage 1 registers
  logic                   valid_s1_reg;
  logic                   fs_s1_reg;
  logic [N-1:0]           eff_s1_reg;
  logic [N*RGB_WIDTH-1:0] rgb_s1_reg;
  logic [RGB_WIDTH-1:0]   bg_s1_reg;
  logic [IDX_W-1:0]       win_s1_reg;
  logic                   any_s1_reg;

  logic [RGB_WIDTH-1:0]   rgb_sel;

  // Effective request and priority table, one slice per object.
  // An index outside 0..N-1 matches no slice, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_obj
      assign eff[gi] = draw_requests[gi] & layer_enable[gi] &
                       (obj_RGB[gi*RGB_WIDTH +: RGB_WIDTH] != TRANSPARENT_RGB);

      always_ff @(posedge clk) begin
        if (reset) begin
          prio_reg[gi*IDX_W +: IDX_W] <= IDX_W'(gi);
        end else if (prio_wr_en && (prio_wr_index == IDX_W'(gi))) begin
          prio_reg[gi*IDX_W +: IDX_W] <= prio_wr_value;
        end
      end
    end
  endgenerate

  // Arbitration happens on the input side with the current table, so a write
  // takes effect for pixels entering on the following cycle and never
  // disturbs a pixel already captured in stage 1.
  objects_mux_arbiter #(
    .NUMBER_OF_OBJECTS (N),
    .IDX_W             (IDX_W)
  ) u_arbiter (
    .eff    (eff),
    .prio   (prio_reg),
    .winner (win_next),
    .any    (any_next)
  );

  // Stage 1: valid always shifts; data only loads on a valid pixel so it
  // holds through gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1_reg <= 1'b0;
      fs_s1_reg    <= 1'b0;
      eff_s1_reg   <= '0;
      rgb_s1_reg   <= '0;
      bg_s1_reg    <= '0;
      win_s1_reg   <= '0;
      any_s1_reg   <= 1'b0;
    end else begin
      valid_s1_reg <= pixel_valid_in;
      if (pixel_valid_in) begin
        fs_s1_reg  <= frame_start;
        eff_s1_reg <= eff;
        rgb_s1_reg <= obj_RGB;
        bg_s1_reg  <= background_RGB;
        win_s1_reg <= win_next;
        any_s1_reg <= any_next;
      end
    end
  end

  assign rgb_sel = rgb_s1_reg[int'(win_s1_reg)*RGB_WIDTH +: RGB_WIDTH];

  // Stage 2: composited outputs, held while no valid pixel arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      RGBOut          <= '0;
      pixel_valid_out <= 1'b0;
      top_index       <= '0;
      any_object      <= 1'b0;
    end else begin
      pixel_valid_out <= valid_s1_reg;
      if (valid_s1_reg) begin
        any_object <= any_s1_reg;
        top_index  <= any_s1_reg ? win_s1_reg : '0;
        RGBOut     <= any_s1_reg ? rgb_sel : bg_s1_reg;
      end
    end
  end

`ifdef OBJECTS_MUX_COLLISION_EN
  logic [N-1:0] collision_reg;
  logic         multi_hit;

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi_hit = |(eff_s1_reg & (eff_s1_reg - N'(1)));

  // A frame-start pixel restarts the flags with its own collisions only.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision_reg <= '0;
    end else if (valid_s1_reg) begin
      if (fs_s1_reg) begin
        collision_reg <= multi_hit ? eff_s1_reg : '0;
      end else if (multi_hit) begin
        collision_reg <= collision_reg | eff_s1_reg;
      end
    end
  end

  assign collision_flags = collision_reg;
`else
  // Frame-start and request history only feed collision detection.
  logic unused_s1;
  assign unused_s1       = ^{fs_s1_reg, eff_s1_reg};
  assign collision_flags = '0;
`endif

endmodule

// File: tb/tb_objects_mux_layered.sv
// -----------------------------------------------------------------------------
// tb_objects_mux_layered
// Directed bench for objects_mux_layered: an 8-object instance for the main
// function and a 6-object instance for out-of-range priority writes.
// -----------------------------------------------------------------------------
module tb_objects_mux_layered;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int IW = 3;

`ifdef OBJECTS_MUX_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           pixel_valid_in;
  logic           frame_start;
  logic [N-1:0]   draw_requests;
  logic [N*W-1:0] obj_RGB;
  logic [W-1:0]   background_RGB;
  logic [N-1:0]   layer_enable;
  logic           prio_wr_en;
  logic [IW-1:0]  prio_wr_index;
  logic [IW-1:0]  prio_wr_value;
  logic [W-1:0]   RGBOut;
  logic           pixel_valid_out;
  logic [IW-1:0]  top_index;
  logic           any_object;
  logic [N-1:0]   collision_flags;

  // 6-object instance
  logic           pv6;
  logic [5:0]     draw6;
  logic [47:0]    rgb6;
  logic           pw6;
  logic [2:0]     pwi6;
  logic [2:0]     pwv6;
  logic [W-1:0]   rgbo6;
  logic           pvo6;
  logic [2:0]     top6;
  logic           any6;
  logic [5:0]     coll6;

  int n_pass  = 0;
  int n_total = 0;

  objects_mux_layered #(.NUMBER_OF_OBJECTS(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_valid_in  (pixel_valid_in),
    .frame_start     (frame_start),
    .draw_requests   (draw_requests),
    .obj_RGB         (obj_RGB),
    .background_RGB  (background_RGB),
    .layer_enable    (layer_enable),
    .prio_wr_en      (prio_wr_en),
    .prio_wr_index   (prio_wr_index),
    .prio_wr_value   (prio_wr_value),
    .RGBOut          (RGBOut),
    .pixel_valid_out (pixel_valid_out),
    .top_index       (top_index),
    .any_object      (any_object),
    .collision_flags (collision_flags)
  );

  objects_mux_layered #(.NUMBER_OF_OBJECTS(6)) dut6 (
    .clk             (clk),
    .reset           (reset),
    .pixel_valid_in  (pv6),
    .frame_start     (1'b0),
    .draw_requests   (draw6),
    .obj_RGB         (rgb6),
    .background_RGB  (background_RGB),
    .layer_enable    (6'h3F),
    .prio_wr_en      (pw6),
    .prio_wr_index   (pwi6),
    .prio_wr_value   (pwv6),
    .RGBOut          (rgbo6),
    .pixel_valid_out (pvo6),
    .top_index       (top6),
    .any_object      (any6),
    .collision_flags (coll6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One valid pixel followed by one idle cycle; outputs are then visible.
  task automatic send(input logic [N-1:0] d, input logic f);
    draw_requests  = d;
    frame_start    = f;
    pixel_valid_in = 1'b1;
    step();
    pixel_valid_in = 1'b0;
    frame_start    = 1'b0;
    step();
  endtask

  task automatic send6(input logic [5:0] d);
    draw6 = d;
    pv6   = 1'b1;
    step();
    pv6   = 1'b0;
    step();
  endtask

  initial begin
    reset          = 1'b1;
    pixel_valid_in = 1'b0;
    frame_start    = 1'b0;
    draw_requests  = '0;
    layer_enable   = 8'hFF;
    background_RGB = 8'h1C;
    prio_wr_en     = 1'b0;
    prio_wr_index  = '0;
    prio_wr_value  = '0;
    for (int i = 0; i < N; i++) obj_RGB[i*W +: W] = 8'h10 + 8'(i);
    pv6   = 1'b0;
    draw6 = '0;
    pw6   = 1'b0;
    pwi6  = '0;
    pwv6  = '0;
    for (int i = 0; i < 6; i++) rgb6[i*W +: W] = 8'h20 + 8'(i);

    step();
    step();
    check("rst_rgb",   RGBOut, 8'h00);
    check("rst_valid", pixel_valid_out, 1'b0);
    check("rst_top",   top_index, 3'd0);
    check("rst_any",   any_object, 1'b0);
    check("rst_coll",  collision_flags, 8'h00);
    reset = 1'b0;

    // Reset while a pixel is in flight: it must never appear.
    draw_requests  = 8'h24;
    frame_start    = 1'b1;
    pixel_valid_in = 1'b1;
    step();
    reset          = 1'b1;
    pixel_valid_in = 1'b0;
    frame_start    = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("discard_v1", pixel_valid_out, 1'b0);
    step();
    check("discard_v2", pixel_valid_out, 1'b0);

    // Objects 2 and 5 with default priorities: 2 wins.
    send(8'h24, 1'b1);
    check("dflt_rgb",   RGBOut, 8'h12);
    check("dflt_top",   top_index, 3'd2);
    check("dflt_any",   any_object, 1'b1);
    check("dflt_valid", pixel_valid_out, 1'b1);
    check("dflt_coll",  collision_flags, COLL ? 8'h24 : 8'h00);
    step();
    check("dflt_vdrop", pixel_valid_out, 1'b0);
    check("dflt_hold",  RGBOut, 8'h12);

    // Priority writes back-to-back with pixels: pixel A entering with the
    // first write sees the old table; B sees prio5=0; C sees both writes.
    draw_requests  = 8'h24;
    pixel_valid_in = 1'b1;
    prio_wr_en     = 1'b1;
    prio_wr_index  = 3'd5;
    prio_wr_value  = 3'd0;
    step();
    prio_wr_index  = 3'd2;
    prio_wr_value  = 3'd7;
    step();
    check("wr_same_top", top_index, 3'd2);
    check("wr_same_rgb", RGBOut, 8'h12);
    prio_wr_en = 1'b0;
    step();
    check("wr_next_top", top_index, 3'd5);
    check("wr_next_rgb", RGBOut, 8'h15);
    pixel_valid_in = 1'b0;
    step();
    check("wr_both_top", top_index, 3'd5);
    step();

    // Tie: prio3 = 0 equals prio5 -> lower index 3 wins.
    prio_wr_en    = 1'b1;
    prio_wr_index = 3'd3;
    prio_wr_value = 3'd0;
    step();
    prio_wr_en = 1'b0;
    send(8'h28, 1'b0);
    check("tie_top", top_index, 3'd3);
    check("tie_rgb", RGBOut, 8'h13);

    // Layer 3 hidden -> 5 wins.
    layer_enable = 8'hF7;
    send(8'h28, 1'b0);
    check("mask_top", top_index, 3'd5);
    check("mask_rgb", RGBOut, 8'h15);
    layer_enable = 8'hFF;

    // Transparent colour is not drawn.
    obj_RGB[1*W +: W] = 8'hFF;
    send(8'h02, 1'b0);
    check("transp_rgb", RGBOut, 8'h1C);
    check("transp_any", any_object, 1'b0);
    check("transp_top", top_index, 3'd0);
    obj_RGB[1*W +: W] = 8'h11;

    // No requests at all.
    background_RGB = 8'h3A;
    send(8'h00, 1'b0);
    check("none_rgb", RGBOut, 8'h3A);
    check("none_any", any_object, 1'b0);
    background_RGB = 8'h1C;
    step();

    // Valid pattern 1,0,1.
    draw_requests  = 8'h10;
    pixel_valid_in = 1'b1;
    step();
    check("gap_v0", pixel_valid_out, 1'b0);
    draw_requests  = 8'h40;
    pixel_valid_in = 1'b0;
    step();
    check("gap_v1",   pixel_valid_out, 1'b1);
    check("gap_rgb1", RGBOut, 8'h14);
    draw_requests  = 8'h80;
    pixel_valid_in = 1'b1;
    step();
    check("gap_v2",    pixel_valid_out, 1'b0);
    check("gap_hold",  RGBOut, 8'h14);
    check("gap_holdt", top_index, 3'd4);
    draw_requests  = 8'h00;
    pixel_valid_in = 1'b0;
    step();
    check("gap_v3",   pixel_valid_out, 1'b1);
    check("gap_rgb3", RGBOut, 8'h17);
    check("gap_top3", top_index, 3'd7);
    step();
    check("gap_v4",   pixel_valid_out, 1'b0);
    check("gap_rgb4", RGBOut, 8'h17);

    // Collisions: objects 0 and 3 overlap (prio tie at 0 -> index 0 wins).
    send(8'h09, 1'b1);
    check("coll_top", top_index, 3'd0);
    check("coll_any", any_object, 1'b1);
    check("coll_rgb", RGBOut, 8'h10);
    check("coll_03",  collision_flags, COLL ? 8'h09 : 8'h00);
    send(8'h02, 1'b1);
    check("coll_clr", collision_flags, 8'h00);
    check("coll_clr_top", top_index, 3'd1);
    send(8'h09, 1'b1);
    send(8'h60, 1'b0);
    check("coll_acc", collision_flags, COLL ? 8'h69 : 8'h00);

    // 6-object instance: writes to indices 6 and 7 must be ignored.
    pw6  = 1'b1;
    pwi6 = 3'd7;
    pwv6 = 3'd0;
    step();
    pwi6 = 3'd6;
    step();
    pw6 = 1'b0;
    send6(6'h24);
    check("oor_top",   top6, 3'd2);
    check("oor_rgb",   rgbo6, 8'h22);
    check("oor_valid", pvo6, 1'b1);
    pw6  = 1'b1;
    pwi6 = 3'd5;
    pwv6 = 3'd0;
    step();
    pw6 = 1'b0;
    send6(6'h24);
    check("inr_top", top6, 3'd5);
    check("inr_rgb", rgbo6, 8'h25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
